// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC engine: quadrant pre-rotation, STAGES micro-rotations and a
// saturating output register, all frozen together by one global stall enable.
module cordic_pipe #(
   parameter int W      = 16,
   parameter int STAGES = 14,
   parameter int TAG_W  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_mode,
   input  logic signed [W-1:0] in_x,
   input  logic signed [W-1:0] in_y,
   input  logic        [W-1:0] in_z,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] out_x,
   output logic signed [W-1:0] out_y,
   output logic        [W-1:0] out_z,
   output logic [TAG_W-1:0]    out_tag,
   output logic                out_ovf
);
   localparam int XW = W + 2;
   localparam logic [W-1:0] QUARTER = {2'b01, {(W-2){1'b0}}};
   localparam logic signed [XW-1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
   localparam logic signed [XW-1:0] SAT_MIN = {3'b111, {(W-1){1'b0}}};

   function automatic logic [STAGES*W-1:0] atan_table();
      logic [STAGES*W-1:0] tab;
      real                 a;
      tab = {(STAGES*W){1'b0}};
      for (int i = 0; i < STAGES; i++) begin
         a = $atan(1.0 / (2.0 ** i)) * (2.0 ** (W - 1)) / 3.14159265358979;
         tab[i*W +: W] = W'($rtoi(a + 0.5));
      end
      return tab;
   endfunction

   localparam logic [STAGES*W-1:0] ATAN_TAB = atan_table();

   // Result bit W flags that the value had to be clipped.
   function automatic logic [W:0] saturate(input logic signed [XW-1:0] v);
      if (v > SAT_MAX) begin
         return {1'b1, SAT_MAX[W-1:0]};
      end else if (v < SAT_MIN) begin
         return {1'b1, SAT_MIN[W-1:0]};
      end else begin
         return {1'b0, v[W-1:0]};
      end
   endfunction

   // Index 0 is the pre-rotation register, index k+1 holds the result of iteration k.
   logic                 v_q [0:STAGES];
   logic                 v_d [0:STAGES];
   logic                 m_q [0:STAGES];
   logic                 m_d [0:STAGES];
   logic signed [XW-1:0] x_q [0:STAGES];
   logic signed [XW-1:0] x_d [0:STAGES];
   logic signed [XW-1:0] y_q [0:STAGES];
   logic signed [XW-1:0] y_d [0:STAGES];
   logic [W-1:0]         z_q [0:STAGES];
   logic [W-1:0]         z_d [0:STAGES];
   logic [TAG_W-1:0]     t_q [0:STAGES];
   logic [TAG_W-1:0]     t_d [0:STAGES];

   logic                 out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
   logic [W-1:0]         out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
   logic [TAG_W-1:0]     out_tag_q, out_tag_d;
   logic [W:0]           sat_x_s, sat_y_s;
   logic                 en_s;

   assign en_s     = out_ready | ~out_valid_q;
   assign in_ready = en_s;

   // Next-state for every pipeline register: pre-rotation, micro-rotations, output clip.
   always_comb begin
      logic signed [XW-1:0] xe, ye, xs, ys;
      logic                 dpos;
      xe = XW'(in_x);
      ye = XW'(in_y);
      xs = {XW{1'b0}};
      ys = {XW{1'b0}};
      dpos = 1'b0;
      v_d[0] = in_valid;
      m_d[0] = in_mode;
      t_d[0] = in_tag;
      if (!in_mode && in_z[W-1:W-2] == 2'b01) begin
         x_d[0] = -ye;
         y_d[0] = xe;
         z_d[0] = in_z - QUARTER;
      end else if (!in_mode && in_z[W-1:W-2] == 2'b10) begin
         x_d[0] = ye;
         y_d[0] = -xe;
         z_d[0] = in_z + QUARTER;
      end else if (in_mode && in_x[W-1] && !in_y[W-1]) begin
         x_d[0] = ye;
         y_d[0] = -xe;
         z_d[0] = in_z + QUARTER;
      end else if (in_mode && in_x[W-1] && in_y[W-1]) begin
         x_d[0] = -ye;
         y_d[0] = xe;
         z_d[0] = in_z - QUARTER;
      end else begin
         x_d[0] = xe;
         y_d[0] = ye;
         z_d[0] = in_z;
      end

      for (int k = 0; k < STAGES; k++) begin
         xs = x_q[k] >>> k;
         ys = y_q[k] >>> k;
         dpos = m_q[k] ? y_q[k][XW-1] : ~z_q[k][W-1];
         v_d[k+1] = v_q[k];
         m_d[k+1] = m_q[k];
         t_d[k+1] = t_q[k];
         if (dpos) begin
            x_d[k+1] = x_q[k] - ys;
            y_d[k+1] = y_q[k] + xs;
            z_d[k+1] = z_q[k] - ATAN_TAB[k*W +: W];
         end else begin
            x_d[k+1] = x_q[k] + ys;
            y_d[k+1] = y_q[k] - xs;
            z_d[k+1] = z_q[k] + ATAN_TAB[k*W +: W];
         end
      end

      sat_x_s     = saturate(x_q[STAGES]);
      sat_y_s     = saturate(y_q[STAGES]);
      out_valid_d = v_q[STAGES];
      out_x_d     = sat_x_s[W-1:0];
      out_y_d     = sat_y_s[W-1:0];
      out_z_d     = z_q[STAGES];
      out_tag_d   = t_q[STAGES];
      out_ovf_d   = sat_x_s[W] | sat_y_s[W];
   end

   // Whole pipeline advances together; bubbles move like samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k <= STAGES; k++) begin
            v_q[k] <= 1'b0;
            m_q[k] <= 1'b0;
            x_q[k] <= {XW{1'b0}};
            y_q[k] <= {XW{1'b0}};
            z_q[k] <= {W{1'b0}};
            t_q[k] <= {TAG_W{1'b0}};
         end
         out_valid_q <= 1'b0;
         out_x_q     <= {W{1'b0}};
         out_y_q     <= {W{1'b0}};
         out_z_q     <= {W{1'b0}};
         out_tag_q   <= {TAG_W{1'b0}};
         out_ovf_q   <= 1'b0;
      end else if (en_s) begin
         for (int k = 0; k <= STAGES; k++) begin
            v_q[k] <= v_d[k];
            m_q[k] <= m_d[k];
            x_q[k] <= x_d[k];
            y_q[k] <= y_d[k];
            z_q[k] <= z_d[k];
            t_q[k] <= t_d[k];
         end
         out_valid_q <= out_valid_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
         out_z_q     <= out_z_d;
         out_tag_q   <= out_tag_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_x     = out_x_q;
   assign out_y     = out_y_q;
   assign out_z     = out_z_q;
   assign out_tag   = out_tag_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cordic_pipe.sv
// Bench for cordic_pipe: directed test-plan vectors, a randomized backpressure stream
// scored against an integer CORDIC reference, and a mid-stream reset.
module tb_cordic_pipe;
   localparam int W       = 16;
   localparam int STAGES  = 14;
   localparam int TAG_W   = 4;
   localparam int QUARTER = 1 << (W - 2);
   localparam int MAXV    = (1 << (W - 1)) - 1;
   localparam int MINV    = -(1 << (W - 1));
   localparam int NSTREAM = 40;

   logic             clk = 1'b0;
   logic             reset, in_valid, in_ready, in_mode, out_valid, out_ready, out_ovf;
   logic [W-1:0]     in_x, in_y, in_z, out_x, out_y, out_z;
   logic [TAG_W-1:0] in_tag, out_tag;

   int          checks = 0;
   int          failures = 0;
   int          atan_tab [STAGES];
   logic [63:0] exp_q [$];

   always #5 clk = ~clk;

   cordic_pipe #(.W(W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_tag(out_tag),
      .out_ovf(out_ovf)
   );

   task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", name, obs, expv);
      end
   endtask

   task automatic check_near(input string name, input int obs, input int expv, input int tol);
      checks++;
      assert ((obs - expv <= tol) && (expv - obs <= tol)) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d (+/-%0d)", name, obs, expv, tol);
      end
   endtask

   function automatic int wrapz(input int v);
      logic signed [W-1:0] t;
      t = v[W-1:0];
      return int'(t);
   endfunction

   function automatic int sx(input logic [W-1:0] v);
      return int'($signed(v));
   endfunction

   function automatic logic [63:0] dut_vec();
      return 64'({out_valid, out_x, out_y, out_z, out_tag, out_ovf});
   endfunction

   function automatic logic [63:0] exp_vec(input int ox, input int oy, input int oz,
                                           input logic [TAG_W-1:0] tag, input logic ovf);
      logic [W-1:0] a, b, c;
      a = ox[W-1:0];
      b = oy[W-1:0];
      c = oz[W-1:0];
      return 64'({1'b1, a, b, c, tag, ovf});
   endfunction

   // Integer CORDIC with z as a signed binary angle; result clamped to W bits.
   task automatic model(input logic mode, input int xi, input int yi, input int zi,
                        output int ox, output int oy, output int oz, output logic ovf);
      int x, y, z, t, xs, ys;
      x = xi; y = yi; z = zi;
      if (!mode && z >= QUARTER) begin t = x; x = -y; y = t; z = wrapz(z - QUARTER); end
      else if (!mode && z < -QUARTER) begin t = x; x = y; y = -t; z = wrapz(z + QUARTER); end
      else if (mode && x < 0 && y >= 0) begin t = x; x = y; y = -t; z = wrapz(z + QUARTER); end
      else if (mode && x < 0) begin t = x; x = -y; y = t; z = wrapz(z - QUARTER); end
      for (int i = 0; i < STAGES; i++) begin
         xs = x >>> i;
         ys = y >>> i;
         if ((!mode && z >= 0) || (mode && y < 0)) begin
            x = x - ys; y = y + xs; z = wrapz(z - atan_tab[i]);
         end else begin
            x = x + ys; y = y - xs; z = wrapz(z + atan_tab[i]);
         end
      end
      ovf = 1'b0;
      if (x > MAXV) begin x = MAXV; ovf = 1'b1; end
      if (x < MINV) begin x = MINV; ovf = 1'b1; end
      if (y > MAXV) begin y = MAXV; ovf = 1'b1; end
      if (y < MINV) begin y = MINV; ovf = 1'b1; end
      ox = x; oy = y; oz = z;
   endtask

   // Sends one sample with no backpressure; returns at the negedge where out_valid shows.
   task automatic run_one(input string name, input logic mode, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] z,
                          input logic [TAG_W-1:0] tag);
      int   ox, oy, oz, edges;
      logic ovf;
      model(mode, sx(x), sx(y), sx(z), ox, oy, oz, ovf);
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_mode = mode;
      in_x = x; in_y = y; in_z = z; in_tag = tag;
      #1;
      check_eq({name, "_in_ready"}, 64'(in_ready), 64'(1'b1));
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (out_valid !== 1'b1 && edges < 100) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check_eq({name, "_latency"}, 64'(edges), 64'(STAGES + 2));
      check_eq({name, "_model"}, dut_vec(), exp_vec(ox, oy, oz, tag, ovf));
   endtask

   initial begin
      int          sent, got, ox, oy, oz;
      logic        ovf, held, acc;
      logic [63:0] held_vec;

      for (int i = 0; i < STAGES; i++)
         atan_tab[i] = $rtoi($atan(1.0 / (2.0 ** i)) * (2.0 ** (W - 1)) / 3.14159265358979 + 0.5);

      reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
      in_x = 16'h0000; in_y = 16'h0000; in_z = 16'h0000; in_tag = 4'h0;
      repeat (2) @(negedge clk);
      check_eq("reset_outputs", dut_vec(), 64'(0));
      reset = 1'b0;
      #1;
      check_eq("reset_in_ready", 64'(in_ready), 64'(1'b1));

      run_one("rot45", 1'b0, 16'h4DBA, 16'h0000, 16'h2000, 4'h5);
      check_near("rot45_x", sx(out_x), 16'h5A82, 4);
      check_near("rot45_y", sx(out_y), 16'h5A82, 4);
      check_near("rot45_z", wrapz(sx(out_z)), 0, 4);
      check_eq("rot45_tag_ovf", 64'({out_tag, out_ovf}), 64'({4'h5, 1'b0}));

      run_one("vec_q2", 1'b1, 16'hE000, 16'h2000, 16'h0000, 4'hA);
      check_near("vec_q2_z", sx(out_z), 16'h6000, 4);
      check_near("vec_q2_x", sx(out_x), 19079, 8);
      check_near("vec_q2_y", sx(out_y), 0, 4);

      run_one("rot_big", 1'b0, 16'h4DBA, 16'h0000, 16'hA000, 4'h3);
      check_near("rot_big_x", sx(out_x), -23170, 4);
      check_near("rot_big_y", sx(out_y), -23170, 4);

      run_one("sat", 1'b0, 16'h7FFF, 16'h0000, 16'h0000, 4'hF);
      check_eq("sat_x_ovf", 64'({out_x, out_ovf}), 64'({16'h7FFF, 1'b1}));

      // Random stream under pseudo-random backpressure.
      @(negedge clk);
      in_valid = 1'b0;
      sent = 0; got = 0; held = 1'b0; acc = 1'b0; held_vec = 64'd0;
      for (int cyc = 0; cyc < 4000 && got < NSTREAM; cyc++) begin
         @(negedge clk);
         if (held) check_eq("stall_hold", dut_vec(), held_vec);
         if (acc) in_valid = 1'b0;
         out_ready = ($urandom_range(0, 1) == 1);
         if (!in_valid && sent < NSTREAM && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_mode  = 1'($urandom_range(0, 1));
            in_x = W'($urandom); in_y = W'($urandom); in_z = W'($urandom);
            in_tag = TAG_W'($urandom);
         end
         #1;
         held = out_valid && !out_ready;
         if (held) begin
            held_vec = dut_vec();
            check_eq("stall_in_ready", 64'(in_ready), 64'(1'b0));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check_eq("stream_spurious", dut_vec(), 64'(0));
            else check_eq("stream_result", dut_vec(), exp_q.pop_front());
            got++;
         end
         acc = in_valid && in_ready;
         if (acc) begin
            model(in_mode, sx(in_x), sx(in_y), sx(in_z), ox, oy, oz, ovf);
            exp_q.push_back(exp_vec(ox, oy, oz, in_tag, ovf));
            sent++;
         end
      end
      check_eq("stream_count", 64'(got), 64'(NSTREAM));
      check_eq("stream_leftover", 64'(exp_q.size()), 64'(0));

      // Reset with eight samples in flight.
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_mode = 1'($urandom_range(0, 1));
         in_x = W'($urandom); in_y = W'($urandom); in_z = W'($urandom); in_tag = TAG_W'(i);
         #1;
         check_eq("rst_fill_ready", 64'(in_ready), 64'(1'b1));
      end
      @(negedge clk);
      in_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("rst_flush_outputs", dut_vec(), 64'(0));
      #1;
      check_eq("rst_in_ready", 64'(in_ready), 64'(1'b1));
      for (int i = 0; i < STAGES + 2; i++) begin
         @(negedge clk);
         check_eq("rst_no_stale", 64'(out_valid), 64'(1'b0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cordic_pipe.md
# cordic_pipe

Parametrised, fully pipelined CORDIC engine. It takes one sample per cycle in either rotation or vectoring mode, selected per sample. It adds quadrant pre-rotation for full-circle convergence, guard bits with output saturation, a sideband tag, and valid/ready backpressure. It is the reusable successor of the single fixed-width iteration stage and sits between the sample source and the downstream mixer/magnitude logic.

## Interface
- W, 16: data width of x/y/z (signed two's complement)
- STAGES, 14: number of micro-rotation iterations, legal range 4..W-1
- TAG_W, 4: sideband tag width, carried unchanged
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  engine accepts the sample this cycle
- in_mode  in  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0)
- in_x, in_y  in  W  signed input vector
- in_z  in  W  signed binary angle; 2^(W-1) = π, so 0x4000 = π/2 at W=16
- in_tag  in  TAG_W  sideband
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_x, out_y  out  W  saturated results
- out_z  out  W  result angle, modular wrap
- out_tag  out  TAG_W  tag of this result
- out_ovf  out  1  out_x or out_y was saturated

## Operation
- Internal x/y width is W+2 (sign-extended); internal z width is W, with modular arithmetic.
- The atan table is computed at elaboration: atan_i = round(atan(2^-i)·2^(W-1)/π), for i = 0..STAGES-1.
- Pipeline: pre-rotation register P, then STAGES iteration registers S0..S(STAGES-1), then output register O. Each register carries valid, mode, x, y, z and tag.
- Pre-rotation, rotation mode:
  - If z[W-1:W-2] = 01: x←−y, y←x, z←z−π/2.
  - If z[W-1:W-2] = 10: x←y, y←−x, z←z+π/2.
  - Otherwise values pass through unchanged.
- Pre-rotation, vectoring mode:
  - If x<0 and y≥0: x←y, y←−x, z←z+π/2.
  - If x<0 and y<0: x←−y, y←x, z←z−π/2.
  - Otherwise values pass through unchanged.
- Iteration i uses d = +1 if (rotation and z≥0) or (vectoring and y<0); otherwise d = −1.
  - x' = x − d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z − d·atan_i
  - Shifts are arithmetic.
- Output stage:
  - x and y are saturated to [−2^(W-1), 2^(W-1)−1].
  - out_ovf = 1 if either clipped.
  - z is truncated (wraps).
- No gain compensation is applied; the gain is ≈1.6468 and the caller pre-scales.
- Stall scheme: global enable en = out_ready | ~out_valid. When en = 0, every register holds. in_ready = en (combinational).
- Bubbles are not compacted: an invalid slot still advances when en = 1.

## Timing
- Latency: STAGES+2 enabled cycles, counted from the in_valid & in_ready edge to out_valid.
- Throughput: 1 sample per cycle while out_ready = 1.
- Reset:
  - All valid bits = 0 and all data/tag registers = 0.
  - out_valid = 0, out_x = out_y = out_z = 0, out_tag = 0, out_ovf = 0.
  - in_ready = 1 on the cycle after reset.
- Reset while samples are in flight: all of them are discarded. out_valid = 0 from the cycle after the reset edge, and no stale result appears after reset deasserts.
- out_valid & ~out_ready: the outputs are held stable and in_ready = 0 in the same cycle.
- in_valid with in_ready = 0: the sample is not captured. The source must hold it.
- in_valid = 0 while en = 1 inserts a bubble.
- Simultaneous output accept and input accept is legal and is the steady state.

## Test plan
- Rotation, W=16, STAGES=14: x=0x4DBA, y=0, z=0x2000, tag=5.
  - Expect out_x ≈ out_y ≈ 0x5A82 (±4 LSB), |out_z| ≤ 4, out_tag=5, out_ovf=0.
  - out_valid asserts exactly 16 cycles after acceptance.
- Vectoring, second quadrant: x=−0x2000, y=0x2000, z=0.
  - Expect out_z ≈ 0x6000 (±4), out_x ≈ 19079 (±8), |out_y| ≤ 4.
- Rotation, large angle: x=0x4DBA, y=0, z=0xA000 (−3π/4).
  - Expect out_x ≈ out_y ≈ −0x5A82 (±4).
  - Confirms pre-rotation.
- Saturation: x=0x7FFF, y=0, z=0.
  - Expect out_x=0x7FFF, out_ovf=1.
- Backpressure: stream 40 samples with out_ready toggled at a pseudo-random 50% duty.
  - Every result must match the reference model in order, with no drops or duplicates.
  - Outputs stay stable while stalled, and in_ready = 0 whenever out_valid & ~out_ready.
- Reset mid-stream: 8 samples in flight, then assert reset for 1 cycle.
  - out_valid = 0 on the next cycle and stays 0 for STAGES+2 idle cycles after reset releases.
  - in_ready = 1.
